// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int unsigned LINE_BITS = 256;
   localparam int unsigned OFFSET_W  = 5;
   localparam int unsigned WORD_W    = OFFSET_W - 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REFILL    = 2'd3
   } state_t;

   function automatic int unsigned index_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned num_lines);
      return addr_w - index_w(num_lines) - OFFSET_W;
   endfunction

endpackage

// File: rtl/dcache_if.sv
// Line-wide data memory bus between the cache controller (master) and memory (slave).
interface dcache_if #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LINE_BITS = dcache_pkg::LINE_BITS
);
   logic                 mem_enable_o;
   logic                 mem_write_o;
   logic [ADDR_W-1:0]    mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;

   modport master (
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport slave (
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line or word write.
module dcache_sram #(
   parameter int unsigned NUM_LINES = 32,
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned TAG_W     = 22,
   parameter int unsigned INDEX_W   = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [INDEX_W-1:0]   index,
   output logic [TAG_W-1:0]     rd_tag,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [LINE_BITS-1:0] rd_line,
   input  logic                 line_we,
   input  logic [TAG_W-1:0]     line_tag,
   input  logic [LINE_BITS-1:0] line_data,
   input  logic                 word_we,
   input  logic [2:0]           word_sel,
   input  logic [31:0]          word_data
);
   logic [LINE_BITS-1:0] data_mem [NUM_LINES];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   assign rd_tag   = tag_mem[index];
   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_line  = data_mem[index];

   always_ff @(posedge clk_i) begin
      if (line_we) begin
         data_mem[index] <= line_data;
         tag_mem[index]  <= line_tag;
      end else if (word_we) begin
         data_mem[index][{word_sel, 5'b00000} +: 32] <= word_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// MEM-stage data cache: direct-mapped, write-back, write-allocate, line-wide refill.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_controller #(
   parameter int unsigned NUM_LINES = 32,
   parameter int unsigned LINE_BITS = dcache_pkg::LINE_BITS,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   dcache_if.master          mem_if,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);
   import dcache_pkg::*;

   localparam int unsigned INDEX_W = index_w(NUM_LINES);
   localparam int unsigned TAG_W   = tag_w(ADDR_W, NUM_LINES);

   state_t state_q, state_d;

   logic [TAG_W-1:0]     cpu_tag;
   logic [INDEX_W-1:0]   cpu_index;
   logic [WORD_W-1:0]    word_sel;
   logic [TAG_W-1:0]     lat_tag_q;
   logic [INDEX_W-1:0]   lat_index_q;
   logic [LINE_BITS-1:0] line_q;
   logic                 ack_q;

   logic [INDEX_W-1:0]   sram_index;
   logic [TAG_W-1:0]     rd_tag;
   logic                 rd_valid;
   logic                 rd_dirty;
   logic [LINE_BITS-1:0] rd_line;

   logic hit, mem_active, ack, stall, latch_addr, line_we, word_we;
   logic unused_addr_bits;

   assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign cpu_index        = cpu_addr_i[OFFSET_W +: INDEX_W];
   assign word_sel         = cpu_addr_i[OFFSET_W-1:2];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign sram_index = (state_q == IDLE) ? cpu_index : lat_index_q;
   assign hit        = cpu_req_i && rd_valid && (rd_tag == cpu_tag);

   // ack_q blanks the request for one cycle after each ack, so back-to-back
   // writeback and allocate show a visible enable drop between them.
   assign mem_active = ((state_q == WRITEBACK) || (state_q == ALLOCATE)) && !ack_q;
   assign ack        = mem_if.mem_ack_i && mem_active;

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .LINE_BITS (LINE_BITS),
      .TAG_W     (TAG_W),
      .INDEX_W   (INDEX_W)
   ) u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .index     (sram_index),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_line   (rd_line),
      .line_we   (line_we),
      .line_tag  (lat_tag_q),
      .line_data (line_q),
      .word_we   (word_we),
      .word_sel  (word_sel),
      .word_data (cpu_data_i)
   );

   always_comb begin
      state_d             = state_q;
      stall               = 1'b0;
      latch_addr          = 1'b0;
      line_we             = 1'b0;
      word_we             = 1'b0;
      mem_if.mem_enable_o = 1'b0;
      mem_if.mem_write_o  = 1'b0;
      mem_if.mem_addr_o   = '0;
      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  word_we = cpu_we_i;
               end else begin
                  stall      = 1'b1;
                  latch_addr = 1'b1;
                  state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            stall               = 1'b1;
            mem_if.mem_enable_o = mem_active;
            mem_if.mem_write_o  = 1'b1;
            mem_if.mem_addr_o   = {rd_tag, lat_index_q, {OFFSET_W{1'b0}}};
            if (ack) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            stall               = 1'b1;
            mem_if.mem_enable_o = mem_active;
            mem_if.mem_addr_o   = {lat_tag_q, lat_index_q, {OFFSET_W{1'b0}}};
            if (ack) state_d = REFILL;
         end
         REFILL: begin
            stall   = 1'b1;
            line_we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_if.mem_data_o = rd_line;
   // While reset is held the emptied cache would otherwise report a miss.
   assign cpu_stall_o = stall && rst_i;
   assign cpu_data_o  = ((state_q == IDLE) && hit && !cpu_we_i) ?
                        rd_line[{word_sel, 5'b00000} +: 32] : '0;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         lat_tag_q   <= '0;
         lat_index_q <= '0;
         line_q      <= '0;
         ack_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack;
         if (latch_addr) begin
            lat_tag_q   <= cpu_tag;
            lat_index_q <= cpu_index;
         end
         if (ack && (state_q == ALLOCATE)) line_q <= mem_if.mem_data_i;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        retry_q;

   // The first IDLE cycle after REFILL is the stalled access retrying.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         retry_q    <= 1'b0;
      end else begin
         retry_q <= (state_q == REFILL);
         if ((state_q == IDLE) && hit && !retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
         if ((state_q == IDLE) && (state_d != IDLE)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed CPU accesses, line memory with 10-cycle ack.
module tb_dcache_controller;

   localparam int LAT = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req, cpu_we, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, hit_cnt, miss_cnt;

   dcache_if #(.ADDR_W(32), .LINE_BITS(256)) mem_bus ();

   dcache_controller #(.NUM_LINES(32), .LINE_BITS(256), .ADDR_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_data_i  (cpu_wdata),
      .cpu_data_o  (cpu_rdata),
      .cpu_stall_o (cpu_stall),
      .mem_if      (mem_bus),
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      int          stall;
      logic [31:0] data;
      string       name;
   } cpu_exp_t;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] line;
   } mem_exp_t;

   cpu_exp_t     cpu_q[$];
   mem_exp_t     mem_q[$];
   logic [255:0] mem_store [logic [31:0]];
   int           total = 0;
   int           bad = 0;
   int           stall_run = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] line_addr, input int w);
      if (line_addr == 32'h40 && w == 0) return 32'hDEAD_BEEF;
      return 32'hA500_0000 | (line_addr << 4) | 32'(w);
   endfunction

   function automatic logic [255:0] default_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(a, w);
      return l;
   endfunction

   function automatic logic [255:0] read_line(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return default_line(a);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_cnt(input string name, input int eh, input int em);
`ifdef DCACHE_STATS_EN
      check32({name, " hits"}, hit_cnt, 32'(eh));
      check32({name, " misses"}, miss_cnt, 32'(em));
`else
      check32({name, " hits"}, hit_cnt, 32'(eh * 0));
      check32({name, " misses"}, miss_cnt, 32'(em * 0));
`endif
   endtask

   task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [255:0] line);
      mem_q.push_back('{wr, addr, line});
   endtask

   // Called at posedge+1; returns at posedge+1 after the access completes.
   task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_stall, input logic [31:0] exp_data, input string name);
      int n;
      cpu_q.push_back('{we, exp_stall, exp_data, name});
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cpu_stall && n < 300);
      if (cpu_stall) begin
         total++; bad++;
         $display("FAIL %s timeout: stall still %0d after %0d cycles, required release", name, cpu_stall, n);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   // CPU response monitor
   initial begin
      cpu_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_run = 0;
         end else if (cpu_req) begin
            if (cpu_stall) begin
               stall_run++;
            end else begin
               if (cpu_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected cpu completion: got addr %h expected none", cpu_addr);
               end else begin
                  e = cpu_q.pop_front();
                  check32({e.name, " stall"}, 32'(stall_run), 32'(e.stall));
                  if (!e.we) check32({e.name, " data"}, cpu_rdata, e.data);
               end
               stall_run = 0;
            end
         end
      end
   end

   // Line memory model and transaction checker
   initial begin
      int       cnt;
      mem_exp_t m;
      cnt = 0;
      mem_bus.mem_ack_i  = 1'b0;
      mem_bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         if (mem_bus.mem_ack_i) begin
            mem_bus.mem_ack_i = 1'b0;
            cnt = 0;
         end else if (rst_n && mem_bus.mem_enable_o) begin
            cnt++;
            if (cnt == LAT) begin
               cnt = 0;
               mem_bus.mem_ack_i = 1'b1;
               if (mem_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected mem txn: got addr %h write %0d expected none",
                           mem_bus.mem_addr_o, mem_bus.mem_write_o);
               end else begin
                  m = mem_q.pop_front();
                  check32("mem addr", mem_bus.mem_addr_o, m.addr);
                  check32("mem write", 32'(mem_bus.mem_write_o), 32'(m.wr));
                  if (m.wr) check_line("mem wb line", mem_bus.mem_data_o, m.line);
               end
               if (mem_bus.mem_write_o) mem_store[mem_bus.mem_addr_o] = mem_bus.mem_data_o;
               else mem_bus.mem_data_i = read_line(mem_bus.mem_addr_o);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      logic [255:0] wb_line;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      #12;
      check32("reset stall", 32'(cpu_stall), 32'd0);
      check32("reset mem_enable", 32'(mem_bus.mem_enable_o), 32'd0);
      check32("reset mem_write", 32'(mem_bus.mem_write_o), 32'd0);
      check_cnt("reset", 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check32("idle no-req data", cpu_rdata, 32'd0);

      push_mem(1'b0, 32'h40, '0);
      cpu_op(1'b0, 32'h40, 32'h0, 12, 32'hDEAD_BEEF, "cold load 0x40");
      cpu_op(1'b1, 32'h44, 32'h1234_5678, 0, 32'h0, "store hit 0x44");
      cpu_op(1'b0, 32'h44, 32'h0, 0, 32'h1234_5678, "load hit 0x44");
      check32("dirty[2] after store", 32'(dut.u_sram.dirty_q[2]), 32'd1);

      wb_line = default_line(32'h40);
      wb_line[63:32] = 32'h1234_5678;
      push_mem(1'b1, 32'h40, wb_line);
      push_mem(1'b0, 32'h440, '0);
      cpu_op(1'b0, 32'h444, 32'h0, 23, 32'hA500_4401, "dirty miss 0x444");
      check32("dirty[2] after refill", 32'(dut.u_sram.dirty_q[2]), 32'd0);
      check_cnt("after dirty miss", 2, 2);

      push_mem(1'b0, 32'h40, '0);
      cpu_op(1'b0, 32'h44, 32'h0, 12, 32'h1234_5678, "refetch written-back 0x44");

      push_mem(1'b0, 32'hA0, '0);
      cpu_op(1'b1, 32'hA0, 32'hCAFE_F00D, 12, 32'h0, "store miss 0xA0");
      check32("dirty[5] after store miss", 32'(dut.u_sram.dirty_q[5]), 32'd1);
      cpu_op(1'b0, 32'hA0, 32'h0, 0, 32'hCAFE_F00D, "load 0xA0");
      cpu_op(1'b0, 32'hA4, 32'h0, 0, 32'hA500_0A01, "load 0xA4");
      cpu_op(1'b0, 32'hBC, 32'h0, 0, 32'hA500_0A07, "load 0xBC");
      check_cnt("after store miss", 5, 4);

      // Abort a refill with an asynchronous reset in the middle of ALLOCATE.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
      repeat (4) @(posedge clk);
      #1;
      check32("allocate enable", 32'(mem_bus.mem_enable_o), 32'd1);
      check32("allocate addr", mem_bus.mem_addr_o, 32'h100);
      #2 rst_n = 1'b0;
      #1;
      check32("mid-reset mem_enable", 32'(mem_bus.mem_enable_o), 32'd0);
      check32("mid-reset mem_write", 32'(mem_bus.mem_write_o), 32'd0);
      check32("mid-reset stall", 32'(cpu_stall), 32'd0);
      check_cnt("mid-reset", 0, 0);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      push_mem(1'b0, 32'h100, '0);
      cpu_op(1'b0, 32'h100, 32'h0, 12, 32'hA500_1000, "post-reset miss 0x100");
      push_mem(1'b0, 32'hA0, '0);
      cpu_op(1'b0, 32'hA0, 32'h0, 12, 32'hA500_0A00, "dirty data lost 0xA0");
      check32("dirty[5] after reset refill", 32'(dut.u_sram.dirty_q[5]), 32'd0);
      check_cnt("after reset", 0, 2);

      repeat (3) @(posedge clk);
      check32("cpu expectations left", 32'(cpu_q.size()), 32'd0);
      check32("mem expectations left", 32'(mem_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- MEM-stage data-cache controller: direct-mapped, write-back, write-allocate.
- Sits between the EX_MEM register and the MEM_WB register.
- Serves loads and stores from the pipeline; its read data feeds MEM_WB memory_data_i.
- Stalls the pipeline on a miss while it evicts the dirty victim and refills from the line-wide data memory.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2); INDEX_W = log2(NUM_LINES).
- LINE_BITS, 256, line width (32 bytes); OFFSET_W = 5.
- ADDR_W, 32, byte address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W (22 at defaults).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- cpu_req_i  in  1  MemRead | MemWrite from EX_MEM.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  byte address (word-aligned).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM; MEM_WB must not capture.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = line write-back.
- mem_addr_o  out  ADDR_W  line-aligned address (offset bits zero).
- mem_data_o  out  LINE_BITS  victim line.
- mem_data_i  in  LINE_BITS  refill line.
- mem_ack_i  in  1  one-cycle completion pulse.
- hit_cnt_o  out  32  see Optional Feature.
- miss_cnt_o  out  32  see Optional Feature.

Behaviour:
- Address split: tag = [ADDR_W-1 : INDEX_W+5], index = [INDEX_W+4 : 5], word select = [4:2].
- hit = cpu_req_i && valid[index] && tag match.
- Reset (rst_i low, async, also mid-operation):
  - state = IDLE; all valid and dirty bits cleared.
  - mem_enable_o, mem_write_o, cpu_stall_o, counters = 0.
  - Any in-flight memory transaction is abandoned; dirty data is lost.
- IDLE:
  - Load hit: cpu_data_o = selected word, combinational, same cycle; cpu_stall_o = 0.
  - Store hit: word written at the rising edge; dirty set; cpu_stall_o = 0.
  - Miss: cpu_stall_o = 1 combinationally; latch address.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
  - No request: cpu_data_o = 0.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - All held stable until mem_ack_i; then go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {latched tag, index, 5'b0}.
  - Held until mem_ack_i.
  - On ack: capture mem_data_i, go to REFILL.
- REFILL (1 cycle):
  - Write line and tag; valid = 1, dirty = 0; go to IDLE.
  - The retried access then hits; a store sets dirty at that point.
- cpu_stall_o is 1 in every state except IDLE, and in IDLE on a miss.
- mem_enable_o is asserted only in WRITEBACK and ALLOCATE, and deasserts the cycle after mem_ack_i.
- Miss latency:
  - Clean miss: ack latency + 2 cycles.
  - Dirty miss: 2 × ack latency + 3 cycles.
- mem_ack_i outside WRITEBACK or ALLOCATE is ignored.
- cpu inputs are stable while stalled. The controller still uses the latched address for the memory transaction.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments once per request that hits on first lookup.
  - miss_cnt_o increments once per miss, on leaving IDLE.
  - The post-refill retry is not counted as a hit.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package dcache_pkg holds:
  - state encoding IDLE = 0, WRITEBACK = 1, ALLOCATE = 2, REFILL = 3;
  - LINE_BITS, OFFSET_W, and the INDEX_W/TAG_W derivation functions.
- Sub-module dcache_sram:
  - tag, valid and dirty arrays plus the data array;
  - combinational read by index;
  - synchronous write of a full line or a single word (dirty update);
  - async-low clear of valid and dirty.

Test Plan:
- Cold load to 0x0000_0040 (memory ack after 10 cycles, line word 0 = 0xDEAD_BEEF) → stall for 12 cycles; one ALLOCATE request to address 0x40; then cpu_data_o = 0xDEAD_BEEF with no stall.
- Store 0x1234_5678 to 0x44 after the line is resident → no stall; a later load of 0x44 returns 0x1234_5678; dirty[2] = 1.
- Load 0x0000_0444 (same index 2, different tag) with line dirty → WRITEBACK to 0x40 carrying the modified line, then ALLOCATE from 0x440; stall = 23 cycles with 10-cycle ack.
- Store miss to clean index 5 (address 0x0A0) → refill, then word written; dirty[5] = 1; other words of the line match memory.
- rst_i pulsed low during ALLOCATE → mem_enable_o = 0 immediately; state IDLE; the next load to the same address misses again.
- With DCACHE_STATS_EN: sequence of miss, hit, hit, dirty miss → hit_cnt_o = 2, miss_cnt_o = 2. Without it, both read 0.
